// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS decode/execute datapath: ALU control codes,
// ALUOp classes, R-type funct values and I-type opcodes.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_NOP = 4'd15;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_SUB    = 2'b01,
    ALUOP_FUNCT  = 2'b10,
    ALUOP_OPCODE = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;

  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  // Operand source chosen by the forwarding unit.
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  function automatic logic [3:0] alu_ctrl_decode(input logic [1:0] alu_op,
                                                 input logic [5:0] funct,
                                                 input logic [5:0] opcode);
    logic [3:0] ctrl;
    ctrl = ALU_NOP;
    case (alu_op_e'(alu_op))
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: ctrl = ALU_ADD;
          FUNCT_SUB: ctrl = ALU_SUB;
          FUNCT_AND: ctrl = ALU_AND;
          FUNCT_OR:  ctrl = ALU_OR;
          FUNCT_SLT: ctrl = ALU_SLT;
          FUNCT_NOR: ctrl = ALU_NOR;
          default:   ctrl = ALU_NOP;
        endcase
      end
      ALUOP_OPCODE: begin
        case (opcode)
          OP_ADDI: ctrl = ALU_ADD;
          OP_ANDI: ctrl = ALU_AND;
          OP_ORI:  ctrl = ALU_OR;
          OP_SLTI: ctrl = ALU_SLT;
          default: ctrl = ALU_NOP;
        endcase
      end
      default: ctrl = ALU_NOP;
    endcase
    return ctrl;
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic imm_is_zext(input logic [5:0] opcode);
    return (opcode == OP_ANDI) || (opcode == OP_ORI);
  endfunction

endpackage

// File: rtl/mips_forward_unit.sv
// Combinational operand-forwarding select for rs/rt; EX/MEM beats MEM/WB and
// register 0 is never forwarded.
module mips_forward_unit
  import mips_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic [RW-1:0] rs,
  input  logic [RW-1:0] rt,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  output fwd_sel_e      fwd_a,
  output fwd_sel_e      fwd_b
);

  function automatic fwd_sel_e pick(input logic [RW-1:0] r,
                                    input logic          ew,
                                    input logic [RW-1:0] erd,
                                    input logic          mw,
                                    input logic [RW-1:0] mrd);
    if (ew && (erd != '0) && (erd == r)) return FWD_EXMEM;
    if (mw && (mrd != '0) && (mrd == r)) return FWD_MEMWB;
    return FWD_REG;
  endfunction

  always_comb begin
    fwd_a = pick(rs, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
    fwd_b = pick(rt, exmem_reg_write, exmem_rd, memwb_reg_write, memwb_rd);
  end

endmodule

// File: rtl/mips_id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, immediate extension,
// operand forwarding and load-use stall/bubble insertion.
module mips_id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [5:0]    id_opcode,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm,
  input  logic [1:0]    id_alu_op,
  input  logic          id_alu_src,
  input  logic          id_reg_dst,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          flush,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          ex_valid,
  output logic [3:0]    ex_alu_ctrl,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write
);

  logic          valid_q, valid_d;
  logic [3:0]    alu_ctrl_q, alu_ctrl_d;
  logic [RW-1:0] rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
  logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d;
  logic          alu_src_q, alu_src_d;
  logic          reg_write_q, reg_write_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;

  logic          hazard;
  fwd_sel_e      fwd_a, fwd_b;
  logic [DW-1:0] fwd_rs, fwd_rt;

  // A load in EX whose destination feeds this instruction must stall one cycle.
  assign hazard = valid_q && mem_read_q && (dest_q != '0) && id_valid &&
                  ((dest_q == id_rs) || ((dest_q == id_rt) && !id_alu_src));
  assign id_ready = !hazard;

  always_comb begin
    valid_d     = id_valid && !flush && !hazard;
    alu_ctrl_d  = alu_ctrl_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    dest_d      = dest_q;
    rs_data_d   = rs_data_q;
    rt_data_d   = rt_data_q;
    imm_d       = imm_q;
    alu_src_d   = alu_src_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (id_ready) begin
      alu_ctrl_d  = alu_ctrl_decode(id_alu_op, id_funct, id_opcode);
      rs_d        = id_rs;
      rt_d        = id_rt;
      dest_d      = id_reg_dst ? id_rd : id_rt;
      rs_data_d   = id_rs_data;
      rt_data_d   = id_rt_data;
      imm_d       = imm_is_zext(id_opcode) ? {{(DW-16){1'b0}}, id_imm}
                                           : {{(DW-16){id_imm[15]}}, id_imm};
      alu_src_d   = id_alu_src;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      alu_ctrl_q  <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      dest_q      <= '0;
      rs_data_q   <= '0;
      rt_data_q   <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      dest_q      <= dest_d;
      rs_data_q   <= rs_data_d;
      rt_data_q   <= rt_data_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  mips_forward_unit #(.RW(RW)) u_fwd (
    .rs              (rs_q),
    .rt              (rt_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b)
  );

  always_comb begin
    case (fwd_a)
      FWD_EXMEM: fwd_rs = exmem_result;
      FWD_MEMWB: fwd_rs = memwb_result;
      default:   fwd_rs = rs_data_q;
    endcase
    case (fwd_b)
      FWD_EXMEM: fwd_rt = exmem_result;
      FWD_MEMWB: fwd_rt = memwb_result;
      default:   fwd_rt = rt_data_q;
    endcase
  end

  assign ex_valid      = valid_q;
  assign ex_alu_ctrl   = alu_ctrl_q;
  assign ex_a          = fwd_rs;
  assign ex_b          = alu_src_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_dest       = dest_q;
  assign ex_reg_write  = reg_write_q && valid_q;
  assign ex_mem_read   = mem_read_q && valid_q;
  assign ex_mem_write  = mem_write_q && valid_q;

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// Directed-vector bench for mips_id_ex_stage with hand-computed expectations.
module tb_mips_id_ex_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid, id_ready;
  logic [5:0]  id_opcode, id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic [1:0]  id_alu_op;
  logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write;
  logic        flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ex_valid;
  logic [3:0]  ex_alu_ctrl;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [4:0]  ex_dest;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  mips_id_ex_stage #(.DW(32), .RW(5)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ex_valid(ex_valid), .ex_alu_ctrl(ex_alu_ctrl),
    .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Load one decoded instruction onto the ID-side inputs.
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] aop,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                       input logic src, input logic dst, input logic rw,
                       input logic mr, input logic mw);
    id_valid = 1'b1;
    id_opcode = op; id_funct = fn; id_alu_op = aop;
    id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
    id_alu_src = src; id_reg_dst = dst;
    id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    drive(6'd0, 6'd0, 2'b00, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    id_valid = 1'b0;
    #12;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_ctrl",  32'(ex_alu_ctrl), 32'd0);
    check("rst_a",     ex_a, 32'd0);
    check("rst_b",     ex_b, 32'd0);
    check("rst_dest",  32'(ex_dest), 32'd0);
    check("rst_ready", 32'(id_ready), 32'd1);
    reset = 1'b0;
    step();

    // slt $9, $2, $3
    drive(6'd0, 6'b101010, 2'b10, 5'd2, 5'd3, 5'd9, 32'd5, 32'd7, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("slt_valid", 32'(ex_valid), 32'd1);
    check("slt_ctrl",  32'(ex_alu_ctrl), 32'd7);
    check("slt_a",     ex_a, 32'd5);
    check("slt_b",     ex_b, 32'd7);
    check("slt_dest",  32'(ex_dest), 32'd9);
    check("slt_rw",    32'(ex_reg_write), 32'd1);
    check("slt_sd",    ex_store_data, 32'd7);

    // ori $6, $1, 0x8001
    drive(6'b001101, 6'd0, 2'b11, 5'd1, 5'd6, 5'd0, 32'd3, 32'd4, 16'h8001, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step();
    check("ori_b",    ex_b, 32'h0000_8001);
    check("ori_ctrl", 32'(ex_alu_ctrl), 32'd1);
    check("ori_dest", 32'(ex_dest), 32'd6);

    // addi, same immediate
    id_opcode = 6'b001000;
    step();
    check("addi_b",    ex_b, 32'hFFFF_8001);
    check("addi_ctrl", 32'(ex_alu_ctrl), 32'd2);

    // andi zero-extends too
    id_opcode = 6'b001100;
    step();
    check("andi_b",    ex_b, 32'h0000_8001);
    check("andi_ctrl", 32'(ex_alu_ctrl), 32'd0);

    // unknown opcode / funct, and the fixed ALUOp classes
    id_opcode = 6'b111111;
    step();
    check("op_other", 32'(ex_alu_ctrl), 32'd15);
    drive(6'd0, 6'b000000, 2'b10, 5'd1, 5'd2, 5'd3, 32'd0, 32'd0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("fn_other", 32'(ex_alu_ctrl), 32'd15);
    id_funct = 6'b100111;
    step();
    check("fn_nor", 32'(ex_alu_ctrl), 32'd12);
    id_alu_op = 2'b01;
    step();
    check("aop_sub", 32'(ex_alu_ctrl), 32'd6);

    // Forwarding on registered rs=4, rt=5
    drive(6'd0, 6'b100000, 2'b10, 5'd4, 5'd5, 5'd7, 32'h11, 32'h22, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    id_valid = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hAA;
    memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hBB;
    #1;
    check("fwd_both",  ex_a, 32'hAA);
    check("fwd_b_reg", ex_b, 32'h22);
    exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb", ex_a, 32'hBB);
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    check("fwd_zero",  ex_a, 32'h11);
    memwb_rd = 5'd5;
    #1;
    check("fwd_rt_b",  ex_b, 32'hBB);
    check("fwd_rt_sd", ex_store_data, 32'hBB);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0; memwb_rd = 5'd0;
    step();

    // lw $8, 4($1) followed by add $10, $8, $3
    drive(6'b100011, 6'd0, 2'b00, 5'd1, 5'd8, 5'd0, 32'h100, 32'd0, 16'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step();
    check("lw_mr",   32'(ex_mem_read), 32'd1);
    check("lw_dest", 32'(ex_dest), 32'd8);
    drive(6'd0, 6'b100000, 2'b10, 5'd8, 5'd3, 5'd10, 32'h33, 32'h44, 16'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu_stall", 32'(id_ready), 32'd0);
    id_rs = 5'd1; id_rt = 5'd8; id_alu_src = 1'b1;
    #1;
    check("lu_immsrc", 32'(id_ready), 32'd1);
    id_rs = 5'd8; id_rt = 5'd3; id_alu_src = 1'b0;
    step();
    check("bub_valid", 32'(ex_valid), 32'd0);
    check("bub_rw",    32'(ex_reg_write), 32'd0);
    check("bub_ready", 32'(id_ready), 32'd1);
    step();
    check("add_valid", 32'(ex_valid), 32'd1);
    check("add_dest",  32'(ex_dest), 32'd10);
    check("add_a",     ex_a, 32'h33);
    check("add_mr",    32'(ex_mem_read), 32'd0);

    // Flush squashes the captured instruction
    drive(6'b101011, 6'd0, 2'b00, 5'd2, 5'd3, 5'd0, 32'd0, 32'd9, 16'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", 32'(ex_valid), 32'd0);
    check("fl_rw",    32'(ex_reg_write), 32'd0);
    check("fl_mw",    32'(ex_mem_write), 32'd0);

    // Asynchronous reset mid-operation
    drive(6'd0, 6'b101010, 2'b10, 5'd2, 5'd3, 5'd9, 32'd5, 32'd7, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    check("pre_valid", 32'(ex_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("ar_valid", 32'(ex_valid), 32'd0);
    check("ar_ctrl",  32'(ex_alu_ctrl), 32'd0);
    check("ar_a",     ex_a, 32'd0);
    check("ar_b",     ex_b, 32'd0);
    check("ar_ready", 32'(id_ready), 32'd1);
    id_valid = 1'b0;
    step();
    reset = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_id_ex_stage.md
Name: mips_id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding stage that feeds the execute-stage ALU (4-bit ALUctrl, 32-bit A/B).
- Captures the decoded instruction, generates ALUctrl from ALUOp/funct/opcode and sign- or zero-extends the immediate.
- Muxes forwarded results from EX/MEM and MEM/WB onto the ALU A/B inputs.
- Detects load-use hazards, stalls the decode stage and inserts a bubble.

Parameters:
- DW, 32, datapath width (A, B, forwarded results)
- RW, 5, register-specifier width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  decode stage presents an instruction
- id_ready  out  1  stage accepts the instruction this cycle; 0 during a load-use stall
- id_opcode  in  6  instruction [31:26]
- id_funct  in  6  instruction [5:0]
- id_rs, id_rt, id_rd  in  RW  register specifiers
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  16  instruction [15:0]
- id_alu_op  in  2  00 add, 01 sub, 10 R-type (funct), 11 I-type (opcode)
- id_alu_src  in  1  1: B = extended immediate
- id_reg_dst  in  1  1: dest = rd, 0: dest = rt
- id_reg_write, id_mem_read, id_mem_write  in  1  control bits
- flush  in  1  squash the instruction being captured (branch taken)
- exmem_reg_write  in  1  EX/MEM writes a register
- exmem_rd  in  RW  EX/MEM destination
- exmem_result  in  DW  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writes a register
- memwb_rd  in  RW  MEM/WB destination
- memwb_result  in  DW  MEM/WB write-back data
- ex_valid  out  1  registered instruction is live
- ex_alu_ctrl  out  4  to ALU ALUctrl
- ex_a, ex_b  out  DW  to ALU A, B (forwarded)
- ex_store_data  out  DW  forwarded rt value for sw
- ex_dest  out  RW  selected destination register
- ex_reg_write, ex_mem_read, ex_mem_write  out  1  control, gated by ex_valid

Behaviour:
- Reset: all registered fields are 0; ex_valid=0; all ex_* outputs 0.
- Latency: 1 cycle. Fields are captured on the clock edge when id_ready=1.
- ex_valid next value = id_valid & ~flush & ~hazard.
- Hazard (load-use), combinational: hazard = ex_valid & ex_mem_read & (ex_dest != 0) & id_valid & ((ex_dest == id_rs) | ((ex_dest == id_rt) & ~id_alu_src)).
  - id_ready = ~hazard.
  - On hazard, ex_valid goes 0 next cycle (bubble) and decode holds.
  - After one bubble the load sits in EX/MEM, so hazard clears.
- flush: captured instruction becomes a bubble (ex_valid=0). Flush wins over hazard. id_ready stays ~hazard.
- ALUctrl decode (registered):
  - ALUOp 00 → 2; ALUOp 01 → 6.
  - ALUOp 10, funct: 100000→2, 100010→6, 100100→0, 100101→1, 101010→7, 100111→12, other→15. Code 15 makes the ALU output 0.
  - ALUOp 11, opcode: 001000→2, 001100→0, 001101→1, 001010→7, other→15.
- Immediate: zero-extended for opcodes 001100 and 001101, sign-extended otherwise.
- ex_dest = id_reg_dst ? id_rd : id_rt. It is registered; ex_dest = 0 suppresses reg_write effect downstream.
- Forwarding (combinational on the registered rs/rt), per operand:
  - If exmem_reg_write & exmem_rd != 0 & exmem_rd == reg → exmem_result.
  - Else if memwb_reg_write & memwb_rd != 0 & memwb_rd == reg → memwb_result.
  - Else the registered read data.
  - EX/MEM has priority when both match.
- ex_a = forwarded rs. ex_store_data = forwarded rt. ex_b = alu_src ? ext_imm : forwarded rt.
- ex_reg_write, ex_mem_read and ex_mem_write are ANDed with ex_valid. Data fields may hold stale values while ex_valid=0.
- Reset mid-stall: asynchronous clear; id_ready=1 while ex_valid=0.

Decomposition:
- Shared package mips_pkg holds:
  - ALUctrl constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7, ALU_NOR=12, ALU_NOP=15.
  - ALUOp codes.
  - funct and opcode constants.
- One sub-module: mips_forward_unit. It is purely combinational; it takes rs/rt and the EX/MEM and MEM/WB ports and returns the two select codes. It is reused by the branch-compare logic later.

Test Plan:
- Reset asserted mid-operation → ex_valid=0, ex_alu_ctrl=0, ex_a=ex_b=0 immediately, without waiting for a clock edge.
- R-type and rs=2 (data 5), rt=3 (data 7), funct 101010 → next cycle ex_alu_ctrl=7, ex_a=5, ex_b=7, ex_dest=rd.
- ori, imm=16'h8001 → ex_b=32'h00008001, ex_alu_ctrl=1. addi, same imm → ex_b=32'hFFFF8001, ex_alu_ctrl=2.
- Registered rs=4, exmem_rd=4 (result 0xAA), memwb_rd=4 (result 0xBB) → ex_a=0xAA. Drop exmem_reg_write → ex_a=0xBB. With rd=0 on both → ex_a = register data.
- lw in EX with dest=8, then add using rs=8 → id_ready=0 for 1 cycle, ex_valid=0 bubble, the add is captured the following cycle.
- flush=1 together with a valid id instruction → ex_valid=0, ex_reg_write=0, ex_mem_write=0 next cycle.
